// File: rtl/regfile_param.sv
// regfile_param: parameterized 2-read/1-write register file with write bypass and a clear sweep FSM
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic              write_reg,
  input  logic [DATA_W-1:0] dst_data,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);
  localparam int NREGS = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;
  assign busy      = state_q == SWEEP;
  assign clr_done  = state_q == DONE;
  assign wr_en     = write_reg && !busy && !(ZERO_R0 && dst_reg == '0);
  assign src_data1 = ZERO_R0 && src_reg1 == '0 ? '0 : BYPASS && wr_en && dst_reg == src_reg1 ? dst_data : regs_q[src_reg1];
  assign src_data2 = ZERO_R0 && src_reg2 == '0 ? '0 : BYPASS && wr_en && dst_reg == src_reg2 ? dst_data : regs_q[src_reg2];
  // sweep walks ptr through every register once; the last one hands off to a single DONE cycle
  always_comb begin
    state_d = state_q == SWEEP ? (&ptr_q ? DONE : SWEEP) : (state_q == IDLE && clr_start) ? SWEEP : IDLE;
    ptr_d   = state_q == SWEEP ? ptr_q + ADDR_W'(1) : '0;
  end
  // sweep owns the write port while busy, otherwise the external write lands
  always_comb begin
    regs_d = regs_q;
    if (busy) regs_d[ptr_q] = '0;
    else if (wr_en) regs_d[dst_reg] = dst_data;
  end
  // state update; reset clears every register in one cycle and aborts any sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed scoreboard bench over default, no-bypass and zero-r0 variants
module tb_regfile_param;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0, clr = 1'b0;
  logic [3:0]  a1 = '0, a2 = '0, dst = '0, sp = '0;
  logic [15:0] din = '0;
  logic [15:0] d1, d2, n1, n2, z1, z2;
  logic        b, bn, bz, c, cn, cz;
  logic [15:0] m [16];
  int          tests = 0, fails = 0;
  typedef struct {string tag; logic [15:0] exp;} exp_t;
  exp_t sbq[$];

  regfile_param dut (.clk(clk), .rst(rst), .src_reg1(a1), .src_reg2(a2), .dst_reg(dst), .write_reg(we),
    .dst_data(din), .src_data1(d1), .src_data2(d2), .clr_start(clr), .busy(b), .clr_done(c));
  regfile_param #(.BYPASS(1'b0)) dut_nb (.clk(clk), .rst(rst), .src_reg1(a1), .src_reg2(a2), .dst_reg(dst),
    .write_reg(we), .dst_data(din), .src_data1(n1), .src_data2(n2), .clr_start(clr), .busy(bn), .clr_done(cn));
  regfile_param #(.ZERO_R0(1'b1)) dut_z (.clk(clk), .rst(rst), .src_reg1(a1), .src_reg2(a2), .dst_reg(dst),
    .write_reg(we), .dst_data(din), .src_data1(z1), .src_data2(z2), .clr_start(clr), .busy(bz), .clr_done(cz));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rd(input logic [3:0] a, input bit byp, input bit z, input bit eb);
    if (z && a == 4'd0) return 16'h0;
    if (byp && we && !eb && dst == a) return din;
    return m[a];
  endfunction

  task automatic push(input string t, input logic [15:0] e);
    exp_t x;
    x.tag = t;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                     input logic w, input logic [15:0] dd, input logic cs);
    a1 = s1; a2 = s2; dst = d; we = w; din = dd; clr = cs;
  endtask

  task automatic step(input bit eb, input bit ed, input string t);
    push({t, "/d1"}, rd(a1, 1'b1, 1'b0, eb));
    push({t, "/d2"}, rd(a2, 1'b1, 1'b0, eb));
    push({t, "/n1"}, rd(a1, 1'b0, 1'b0, eb));
    push({t, "/n2"}, rd(a2, 1'b0, 1'b0, eb));
    push({t, "/z1"}, rd(a1, 1'b1, 1'b1, eb));
    push({t, "/z2"}, rd(a2, 1'b1, 1'b1, eb));
    push({t, "/busy_done"}, {10'b0, eb, eb, eb, ed, ed, ed});
    @(negedge clk);
    pop_chk(d1); pop_chk(d2); pop_chk(n1); pop_chk(n2); pop_chk(z1); pop_chk(z2);
    pop_chk({10'b0, b, bn, bz, c, cn, cz});
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) m[i] = '0;
      sp = '0;
    end else if (eb) begin
      m[sp] = '0;
      sp = sp + 4'd1;
    end else if (we) m[dst] = din;
    #1;
  endtask

  initial begin
    foreach (m[i]) m[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin set(4'(i), 4'(15 - i), 4'd0, 1'b0, 16'h0, 1'b0); step(0, 0, "reset_read"); end
    set(4'd0, 4'd1, 4'd5, 1'b1, 16'hBEEF, 1'b0); step(0, 0, "wr_r5");
    set(4'd5, 4'd5, 4'd0, 1'b0, 16'h0, 1'b0); step(0, 0, "rd_r5");
    set(4'd3, 4'd7, 4'd3, 1'b1, 16'h1234, 1'b0); step(0, 0, "byp_p1");
    set(4'd3, 4'd7, 4'd7, 1'b1, 16'h5678, 1'b0); step(0, 0, "byp_p2");
    set(4'd0, 4'd1, 4'd0, 1'b1, 16'hFFFF, 1'b0); step(0, 0, "wr_r0");
    set(4'd0, 4'd1, 4'd1, 1'b1, 16'h1111, 1'b0); step(0, 0, "wr_r1");
    set(4'd0, 4'd1, 4'd0, 1'b0, 16'h0, 1'b0); step(0, 0, "rd_r0_r1");
    for (int i = 0; i < 16; i++) begin set(4'(i), 4'(i + 1), 4'(i), 1'b1, 16'($urandom) | 16'h1, 1'b0); step(0, 0, "fill"); end
    set(4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 1'b1); step(0, 0, "clr_req");
    for (int k = 0; k < 16; k++) begin
      if (k == 4) set(4'd4, 4'd15, 4'd15, 1'b1, 16'hAAAA, 1'b1);
      else set(4'(k), 4'(k + 8), 4'd0, 1'b0, 16'h0, 1'b0);
      step(1, 0, "sweep");
    end
    set(4'd2, 4'd15, 4'd2, 1'b1, 16'h4242, 1'b0); step(0, 1, "done_wr");
    for (int i = 0; i < 16; i++) begin set(4'(i), 4'(i), 4'd0, 1'b0, 16'h0, 1'b0); step(0, 0, "post_clr"); end
    set(4'd9, 4'd9, 4'd9, 1'b1, 16'h9999, 1'b1); step(0, 0, "wr_and_clr");
    for (int k = 0; k < 16; k++) begin set(4'd9, 4'(k), 4'd0, 1'b0, 16'h0, 1'b0); step(1, 0, "sweep2"); end
    set(4'd9, 4'd2, 4'd0, 1'b0, 16'h0, 1'b0); step(0, 1, "done2");
    step(0, 0, "after2");
    set(4'd4, 4'd12, 4'd4, 1'b1, 16'h4444, 1'b0); step(0, 0, "wr_r4");
    set(4'd4, 4'd12, 4'd12, 1'b1, 16'hCCCC, 1'b0); step(0, 0, "wr_r12");
    set(4'd4, 4'd12, 4'd0, 1'b0, 16'h0, 1'b1); step(0, 0, "clr3");
    for (int k = 0; k < 8; k++) begin set(4'd4, 4'd12, 4'd0, 1'b0, 16'h0, 1'b0); step(1, 0, "sweep3"); end
    rst = 1'b1; step(1, 0, "rst_mid");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 0, "post_rst");
    for (int i = 0; i < 16; i++) begin set(4'(i), 4'(15 - i), 4'd0, 1'b0, 16'h0, 1'b0); step(0, 0, "rst_read"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
